spi_pixel_stream_bridge: RTL and testbench
==========================================

Name: spi_pixel_stream_bridge

Overview:
- Single-clock SPI-slave-to-pixel-stream bridge; successor to the fixed 24-bit SPI control block.
- Oversamples SPI pins on clk_i, so there is no SPI-clock domain.
- Generalised to any byte-multiple pixel width, with a configurable byte order.
- Buffers both directions in FIFOs with valid/ready handshakes to the Sobel pipeline, and reports overflow/underrun.

Parameters:
- PX_BITS, 24, pixel word width; must be a multiple of 8 and at least 8.
- RX_DEPTH, 4, RX FIFO entries (SPI to pipeline); power of 2, at least 2.
- TX_DEPTH, 4, TX FIFO entries (pipeline to SPI); power of 2, at least 2.
- BYTE_SWAP, 1, 1: byte 0 (bits 7:0) on the wire first, MSB-first within each byte; 0: whole word MSB-first.
- UNDERRUN_PX, 0, word shifted out when the TX FIFO is empty at word start.

Ports:
- clk_i  in  1  system clock; must be at least 8x the SCK frequency.
- reset_i  in  1  asynchronous active-high reset.
- spi_sck_i  in  1  SPI clock, mode 0.
- spi_sdi_i  in  1  MOSI.
- spi_cs_i  in  1  chip select, active low.
- spi_sdo_o  out  1  MISO.
- px_o  out  PX_BITS  RX FIFO head.
- px_valid_o  out  1  RX FIFO not empty.
- px_ready_i  in  1  pipeline accepts px_o.
- px_i  in  PX_BITS  processed pixel from the pipeline.
- px_valid_i  in  1  px_i valid.
- px_ready_o  out  1  TX FIFO not full.
- rx_level_o  out  $clog2(RX_DEPTH)+1  RX occupancy.
- tx_level_o  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_overflow_o  out  1  1-cycle pulse: a received word was dropped.
- tx_underrun_o  out  1  1-cycle pulse: UNDERRUN_PX was loaded.
- err_cnt_o  out  16  {rx_drop_cnt[7:0], tx_undr_cnt[7:0]}.

Behaviour:
- Reset (asynchronous, active high):
  - Synchroniser flops: sck=0, cs=1, sdi=0.
  - FIFOs empty; bit counter 0; shift registers 0.
  - spi_sdo_o=0, px_valid_o=0, px_ready_o=1, levels 0, pulses 0, err_cnt_o=0.
  - Reset mid-frame drops the partial word and all buffered words.
- Input sync: 2-flop synchroniser per SPI input. Edges are detected from the synchronised sck against its 1-cycle delayed copy.
- SPI FSM states: IDLE, LOAD, SHIFT.
  - IDLE: stays while cs is high; spi_sdo_o=0. Goes to LOAD on the synchronised cs falling edge.
  - LOAD: one cycle. Pops the TX FIFO into the TX shift register; if empty, loads UNDERRUN_PX and pulses tx_underrun_o. spi_sdo_o takes the first wire bit. Goes to SHIFT.
  - SHIFT, sck rising: sample sdi into the RX shift register; bit counter +1.
  - SHIFT, sck falling: advance the TX shift register. Skipped on the falling edge that follows the word's last bit; LOAD supplies the next bit instead.
  - SHIFT, counter reaches PX_BITS: push the RX word (byte-reordered per BYTE_SWAP) the same cycle; counter to 0; go to LOAD (back-to-back words in one CS frame).
  - Any state, cs rises: go to IDLE; counter to 0; partial RX bits and the popped TX word are discarded. No push, no error.
- RX push when the RX FIFO is full: word dropped, rx_overflow_o pulses, FIFO contents unchanged.
- Latency: a word is on px_valid_o 1 clk after the completing synchronised rising edge, i.e. 3 clk after the pin edge.
- FIFO rules:
  - Pop happens when valid and ready.
  - px_i is pushed when px_valid_i and px_ready_o.
  - Full blocks push even with a same-cycle pop.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
  - Pointers wrap modulo depth.
  - px_o is stable while px_valid_o is high and not popped.
- Simultaneous SPI pop (LOAD) and pipeline push to the TX FIFO obey the same FIFO rules.

Optional Feature:
- Macro: SPI_BRIDGE_ERR_CNT_EN.
- Defined: two 8-bit saturating counters (RX drops, TX underruns), each incremented by its pulse; they saturate at 255 and clear only on reset.
- Undefined: no counters; err_cnt_o is tied to 0. The pulses remain.

Decomposition:
- Shared package gains SPI_MODE0 constants, spi_state_e (IDLE/LOAD/SHIFT), and MAX_PIXEL_BITS as the PX_BITS default.
- Submodule sync_fifo #(WIDTH, DEPTH): count-based level, full/empty, instantiated twice.
- Byte reordering is a function in the package.

Test Plan:
- PX_BITS=24, BYTE_SWAP=1: send bytes 0x11,0x22,0x33 in one CS frame, pipeline ready → px_o=0x332211 with one valid beat.
- Preload TX 0xABCDEF, then a 24-bit frame → MISO bytes 0xEF,0xCD,0xAB. With the TX FIFO empty → 0x000000 and one tx_underrun_o pulse.
- px_ready_i=0: send 5 words with RX_DEPTH=4 → rx_level_o=4, one rx_overflow_o pulse; pops return words 1–4 in order.
- Raise CS after 13 bits, then send a full word 0x0000FF → only 0x0000FF pushed, no error.
- Assert reset mid-word with 2 words buffered → all outputs at reset values, levels 0, no stale pixel afterwards.
- With SPI_BRIDGE_ERR_CNT_EN: force 300 underruns → err_cnt_o[7:0]=255. Without the macro: err_cnt_o=0.

Source files
------------

// File: rtl/spi_pixel_stream_bridge_pkg.sv
// Shared definitions for the SPI-to-pixel-stream bridge: SPI mode, FSM states, byte ordering.
package spi_pixel_stream_bridge_pkg;

  // SPI mode 0: SCK idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int unsigned MAX_PIXEL_BITS = 24;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } spi_state_e;

  // Source byte index for pixel byte idx; byte reversal is its own inverse, so RX and TX share it.
  function automatic int unsigned wire_byte_idx(input int unsigned idx,
                                                input int unsigned nbytes,
                                                input logic        swap);
    return swap ? (nbytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/spi_pixel_stream_bridge_sync_fifo.sv
// Count-based synchronous FIFO; a push is refused when full even if a pop happens that cycle.
module spi_pixel_stream_bridge_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + LW'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - LW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_pixel_stream_bridge.sv
// Oversampled SPI mode-0 slave bridging to valid/ready pixel streams through RX/TX FIFOs.
// Optional saturating error counters are built when SPI_BRIDGE_ERR_CNT_EN is defined.
module spi_pixel_stream_bridge
  import spi_pixel_stream_bridge_pkg::*;
#(
  parameter int unsigned        PX_BITS     = MAX_PIXEL_BITS,
  parameter int unsigned        RX_DEPTH    = 4,
  parameter int unsigned        TX_DEPTH    = 4,
  parameter int unsigned        BYTE_SWAP   = 1,
  parameter logic [PX_BITS-1:0] UNDERRUN_PX = '0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        spi_sck_i,
  input  logic                        spi_sdi_i,
  input  logic                        spi_cs_i,
  output logic                        spi_sdo_o,
  output logic [PX_BITS-1:0]          px_o,
  output logic                        px_valid_o,
  input  logic                        px_ready_i,
  input  logic [PX_BITS-1:0]          px_i,
  input  logic                        px_valid_i,
  output logic                        px_ready_o,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic                        rx_overflow_o,
  output logic                        tx_underrun_o,
  output logic [15:0]                 err_cnt_o
);

  localparam int unsigned CNT_W          = $clog2(PX_BITS);
  localparam int unsigned NBYTES         = PX_BITS / 8;
  localparam logic        SWAP           = (BYTE_SWAP != 0);
  localparam logic        SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  logic [1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
  logic       sck_prev_q, cs_prev_q;
  logic       sck_s, cs_s, sdi_s, sck_rise, sck_fall, sample_edge, shift_edge, cs_fall;

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PX_BITS-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_word, tx_src, tx_head;
  logic               rx_push, rx_full, rx_empty, tx_pop, tx_full, tx_empty, underrun;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sck_sync_q <= {2{SPI_CPOL}};
      cs_sync_q  <= 2'b11;
      sdi_sync_q <= 2'b00;
      sck_prev_q <= SPI_CPOL;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[0], spi_sck_i};
      cs_sync_q  <= {cs_sync_q[0], spi_cs_i};
      sdi_sync_q <= {sdi_sync_q[0], spi_sdi_i};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign sck_s       = sck_sync_q[1];
  assign cs_s        = cs_sync_q[1];
  assign sdi_s       = sdi_sync_q[1];
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
  assign cs_fall     = cs_prev_q & ~cs_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_sr_d  = rx_sr_q;
    tx_sr_d  = tx_sr_q;
    rx_push  = 1'b0;
    tx_pop   = 1'b0;
    underrun = 1'b0;
    tx_src   = tx_empty ? UNDERRUN_PX : tx_head;
    rx_word  = '0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StLoad;
      end
      StLoad: begin
        tx_pop   = ~tx_empty;
        underrun = tx_empty;
        for (int unsigned i = 0; i < NBYTES; i++) begin
          tx_sr_d[i*8 +: 8] = tx_src[wire_byte_idx(i, NBYTES, SWAP)*8 +: 8];
        end
        state_d = StShift;
      end
      StShift: begin
        if (sample_edge) begin
          rx_sr_d = {rx_sr_q[PX_BITS-2:0], sdi_s};
          if (cnt_q == CNT_W'(PX_BITS - 1)) begin
            rx_push = 1'b1;
            cnt_d   = '0;
            state_d = StLoad;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (shift_edge && cnt_q != '0) begin
          // A shift edge at count 0 trails the previous word; LOAD already presented bit 0.
          tx_sr_d = {tx_sr_q[PX_BITS-2:0], 1'b0};
        end
      end
      default: state_d = StIdle;
    endcase

    for (int unsigned i = 0; i < NBYTES; i++) begin
      rx_word[i*8 +: 8] = rx_sr_d[wire_byte_idx(i, NBYTES, SWAP)*8 +: 8];
    end

    if (cs_s) begin
      state_d = StIdle;
      cnt_d   = '0;
      rx_sr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
    end
  end

  assign spi_sdo_o     = (state_q != StIdle) & tx_sr_q[PX_BITS-1];
  assign rx_overflow_o = rx_push & rx_full;
  assign tx_underrun_o = underrun;
  assign px_valid_o    = ~rx_empty;
  assign px_ready_o    = ~tx_full;

  spi_pixel_stream_bridge_sync_fifo #(
    .WIDTH (PX_BITS),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (rx_push),
    .wdata_i (rx_word),
    .pop_i   (px_ready_i),
    .rdata_o (px_o),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level_o)
  );

  spi_pixel_stream_bridge_sync_fifo #(
    .WIDTH (PX_BITS),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (px_valid_i),
    .wdata_i (px_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

`ifdef SPI_BRIDGE_ERR_CNT_EN
  logic [7:0] rx_drop_cnt_q, tx_undr_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_drop_cnt_q <= '0;
      tx_undr_cnt_q <= '0;
    end else begin
      if (rx_overflow_o && rx_drop_cnt_q != 8'hff) rx_drop_cnt_q <= rx_drop_cnt_q + 8'd1;
      if (tx_underrun_o && tx_undr_cnt_q != 8'hff) tx_undr_cnt_q <= tx_undr_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = {rx_drop_cnt_q, tx_undr_cnt_q};
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spi_pixel_stream_bridge.sv
// Scoreboard bench: an SPI master task drives frames, monitors compare RX pixels and MISO words.
module tb_spi_pixel_stream_bridge;

  localparam int HALF = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        spi_sck_i = 1'b0, spi_sdi_i = 1'b0, spi_cs_i = 1'b1;
  logic        spi_sdo_o;
  logic [23:0] px_o, px_i = '0;
  logic        px_valid_o, px_ready_i = 1'b1, px_valid_i = 1'b0, px_ready_o;
  logic [2:0]  rx_level_o, tx_level_o;
  logic        rx_overflow_o, tx_underrun_o;
  logic [15:0] err_cnt_o;

  int          checks = 0, failures = 0;
  int          undr_cnt = 0, ovf_cnt = 0, undr_at_last = 0, base_u, base_o;
  logic [23:0] exp_rx_q[$], exp_miso_q[$];
  logic [23:0] miso_cap = '0;
  event        miso_done;

  spi_pixel_stream_bridge #(
    .PX_BITS     (24),
    .RX_DEPTH    (4),
    .TX_DEPTH    (4),
    .BYTE_SWAP   (1),
    .UNDERRUN_PX (24'h000000)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .spi_sck_i     (spi_sck_i),
    .spi_sdi_i     (spi_sdi_i),
    .spi_cs_i      (spi_cs_i),
    .spi_sdo_o     (spi_sdo_o),
    .px_o          (px_o),
    .px_valid_o    (px_valid_o),
    .px_ready_i    (px_ready_i),
    .px_i          (px_i),
    .px_valid_i    (px_valid_i),
    .px_ready_o    (px_ready_o),
    .rx_level_o    (rx_level_o),
    .tx_level_o    (tx_level_o),
    .rx_overflow_o (rx_overflow_o),
    .tx_underrun_o (tx_underrun_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Wire order: byte 0 first, MSB first within each byte.
  task automatic send_word(input logic [23:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      int pos;
      pos = (k / 8) * 8 + 7 - (k % 8);
      spi_sdi_i = w[pos];
      tick(HALF);
      spi_sck_i = 1'b1;
      miso_cap[pos] = spi_sdo_o;
      undr_at_last = undr_cnt;
      tick(HALF);
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    base_u = undr_cnt;
    base_o = ovf_cnt;
    spi_cs_i = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_cs_i = 1'b1;
    tick(HALF);
  endtask

  task automatic tx_preload(input logic [23:0] w);
    px_i = w;
    px_valid_i = 1'b1;
    tick(1);
    px_valid_i = 1'b0;
  endtask

  task automatic wait_rx_drain(input string name);
    for (int i = 0; i < 300 && exp_rx_q.size() != 0; i++) tick(1);
    check(name, exp_rx_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (!reset_i && tx_underrun_o) undr_cnt++;
    if (!reset_i && rx_overflow_o) ovf_cnt++;
  end

  // RX monitor: one comparison per accepted beat.
  always @(negedge clk_i) begin
    if (!reset_i && px_valid_o && px_ready_i) begin
      if (exp_rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected got=%0h exp=none", px_o);
      end else begin
        check("rx_px", px_o, exp_rx_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(miso_done);
      if (exp_miso_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL miso_unexpected got=%0h exp=none", miso_cap);
      end else begin
        check("miso_word", miso_cap, exp_miso_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check("rst_sdo", spi_sdo_o, 0);
    check("rst_px_valid", px_valid_o, 0);
    check("rst_px_ready", px_ready_o, 1);
    check("rst_rx_level", rx_level_o, 0);
    check("rst_tx_level", tx_level_o, 0);
    check("rst_pulses", {rx_overflow_o, tx_underrun_o}, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    reset_i = 1'b0;
    tick(4);

    // Bytes 0x11,0x22,0x33 on the wire assemble to 0x332211.
    exp_rx_q.push_back(24'h332211);
    cs_low();
    send_word(24'h332211, 24);
    cs_high();
    wait_rx_drain("rx_drain_basic");

    // TX preload shows up as MISO bytes EF,CD,AB; no underrun at word start.
    tx_preload(24'hABCDEF);
    check("tx_level_preload", tx_level_o, 1);
    exp_miso_q.push_back(24'hABCDEF);
    exp_rx_q.push_back(24'h0A0B0C);
    cs_low();
    send_word(24'h0A0B0C, 24);
    check("undr_with_data", undr_at_last - base_u, 0);
    -> miso_done;
    cs_high();
    check("tx_level_popped", tx_level_o, 0);

    // Empty TX FIFO: underrun word and exactly one pulse at word start.
    exp_miso_q.push_back(24'h000000);
    exp_rx_q.push_back(24'h00C0DE);
    cs_low();
    send_word(24'h00C0DE, 24);
    check("undr_empty", undr_at_last - base_u, 1);
    -> miso_done;
    cs_high();
    wait_rx_drain("rx_drain_tx");

    // Five back-to-back words into a 4-deep RX FIFO with the sink stalled.
    px_ready_i = 1'b0;
    cs_low();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_rx_q.push_back(24'h100000 * i + 24'h000101 * i);
      send_word(24'h100000 * i + 24'h000101 * i, 24);
    end
    cs_high();
    check("ovf_level", rx_level_o, 4);
    check("ovf_pulses", ovf_cnt - base_o, 1);
    check("ovf_valid", px_valid_o, 1);
    px_ready_i = 1'b1;
    wait_rx_drain("rx_drain_ovf");
    check("ovf_level_drained", rx_level_o, 0);

    // Aborted 13-bit word is discarded; the following full word is the only one pushed.
    cs_low();
    send_word(24'hFFFFFF, 13);
    cs_high();
    exp_rx_q.push_back(24'h0000FF);
    cs_low();
    send_word(24'h0000FF, 24);
    cs_high();
    check("partial_no_ovf", ovf_cnt - base_o, 0);
    wait_rx_drain("rx_drain_partial");

    // Reset mid-word with two words buffered and one TX word queued.
    px_ready_i = 1'b0;
    cs_low();
    send_word(24'h123456, 24);
    send_word(24'h654321, 24);
    tx_preload(24'h777777);
    send_word(24'h5A5A5A, 10);
    check("pre_rst_rx_level", rx_level_o, 2);
    check("pre_rst_tx_level", tx_level_o, 1);
    reset_i = 1'b1;
    tick(2);
    check("mid_rst_px_valid", px_valid_o, 0);
    check("mid_rst_levels", {rx_level_o, tx_level_o}, 0);
    check("mid_rst_sdo", spi_sdo_o, 0);
    check("mid_rst_px_ready", px_ready_o, 1);
    spi_cs_i = 1'b1;
    spi_sck_i = 1'b0;
    tick(2);
    reset_i = 1'b0;
    px_ready_i = 1'b1;
    tick(40);
    check("post_rst_px_valid", px_valid_o, 0);
    check("post_rst_rx_level", rx_level_o, 0);

    // Each CS falling edge on an empty TX FIFO is one underrun.
    base_o = ovf_cnt;
    for (int i = 0; i < 300; i++) begin
      spi_cs_i = 1'b0;
      tick(6);
      spi_cs_i = 1'b1;
      tick(6);
    end
    check("toggle_undr_pulses", undr_cnt - base_u, 300);
`ifdef SPI_BRIDGE_ERR_CNT_EN
    check("err_undr_sat", err_cnt_o[7:0], 8'hFF);
    check("err_drop_cleared", err_cnt_o[15:8], 0);
`else
    check("err_cnt_tied", err_cnt_o, 0);
`endif
    check("final_queues", exp_rx_q.size() + exp_miso_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Underrun base for the toggle loop is taken after reset so earlier frames do not count.
  initial begin
    @(negedge reset_i);
    @(posedge reset_i);
    @(negedge reset_i);
    base_u = undr_cnt;
  end

endmodule
